sprite_fetch_arbiter: RTL
=========================

// Module: sprite_fetch_arbiter
// PURPOSE
// Shares the single read port of the sprite ROM among NUM_REQ sprite engines
// (player, alien rows, bullets, UFO). Each engine requests a burst: one sprite line of pixels.
// The arbiter grants requesters round-robin and drives the ROM address for each pixel.
// It routes the returned pixel data back to the owner, tagged with a per-requester valid.
// Sits between the sprite engines and the sprite ROM, clocked on the pixel clock.
// PARAMETERS
// NUM_REQ  4   number of requesters (1..8)
// ADDR_W   19  ROM address width
// DATA_W   24  pixel colour width (RGB888)
// LEN_W    6   burst length width; max burst = 2**LEN_W-1 pixels
// ROM_LAT  1   ROM read latency in clocks (1..3)
// PORTS
// Clk       in   1               pixel clock; all logic on posedge
// Reset     in   1               asynchronous, active-low reset
// req       in   NUM_REQ         per-requester burst request; level, held until gnt
// req_addr  in   NUM_REQ*ADDR_W  burst start address; slice i belongs to requester i
// req_len   in   NUM_REQ*LEN_W   burst length in pixels; slice i belongs to requester i
// gnt       out  NUM_REQ         one-hot, 1-cycle pulse on burst acceptance
// busy      out  1               high from the grant cycle through the last address issued
// rom_addr  out  ADDR_W          address to the sprite ROM
// rom_re    out  1               ROM read enable; one pixel per cycle
// rom_data  in   DATA_W          ROM output, valid ROM_LAT clocks after rom_re
// rd_data   out  DATA_W          rom_data broadcast to all requesters
// rd_valid  out  NUM_REQ         one-hot; rd_data belongs to requester i
// rd_last   out  1               high with the final pixel of a burst
// BEHAVIOUR
// - Reset low: all outputs 0; state IDLE; round-robin pointer = 0; return pipeline flushed.
//   Asserting reset mid-burst drops the burst. No rd_valid is emitted for addresses already in flight.
// - FSM IDLE:
//   - If any req is high, grant the first requester at or after ptr, with wraparound.
//   - The grant cycle pulses gnt[i], latches addr/len/owner, and enters BURST.
//   - rom_re/rom_addr are first driven in the grant cycle, using req_addr[i] directly.
// - FSM BURST:
//   - Each cycle: rom_re=1, rom_addr = start + count. count goes 1..len-1.
//   - After the last address: ptr = owner+1 mod NUM_REQ.
//   - Next: if any req is high, grant again in the same cycle (back-to-back, no bubble); else IDLE.
// - len==0 is treated as len==1. len==1 completes in the grant cycle alone.
// - Requester must hold req/req_addr/req_len stable until gnt. Values are latched at gnt.
//   req dropping mid-burst does not abort the burst.
// - A requester's req sampled during its own burst is not re-granted before the burst ends.
//   Round-robin guarantees every other pending requester is served first.
// - Return path: {valid, owner, last} shift pipeline of depth ROM_LAT.
//   rd_valid[owner] = 1 and rd_data = rom_data exactly ROM_LAT clocks after each rom_re.
//   rd_last marks the final pixel.
// - rom_addr wraps modulo 2**ADDR_W. No overflow flag.
// - rd_data holds the last value when rd_valid==0. rom_addr is 0 when rom_re==0.
// - busy = 1 in any cycle with rom_re=1.
// - Throughput: 1 pixel/clock sustained. Grant latency from req to gnt with arbiter idle: 0 clocks (combinational).
// TESTING
// 1. Reset, req=0001, addr0=0x100, len0=4.
//    -> gnt=0001 at t0; rom_addr 0x100..0x103 at t0..t3.
//    -> rd_valid=0001 at t1..t4; rd_last at t4; busy t0..t3.
// 2. req=1111 held, all len=2.
//    -> grants in order 0,1,2,3,0, each 2 cycles apart, no idle cycles.
//    -> rd_valid owners match the grant order, delayed ROM_LAT.
// 3. ptr=2 after serving req 1, then req=0011.
//    -> next gnt=0001 (wrap); req 1 waits one burst.
// 4. len=0 and len=63 bursts.
//    -> 1 and 63 rom_re cycles respectively; rd_last on the final pixel only.
// 5. Reset pulsed low mid-burst (count=2 of 8).
//    -> outputs 0 the same edge; no rd_valid afterward; ptr=0.
//    -> the next req is granted normally.
// 6. ROM_LAT=3, addr=0x7FFFE, len=4.
//    -> rom_addr 0x7FFFE,0x7FFFF,0x00000,0x00001.
//    -> rd_valid 3 clocks after each rom_re.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// Sprite ROM fetch arbiter: round-robin burst grants among NUM_REQ sprite engines on one ROM read port.
// Latency: gnt and the first rom_addr are combinational in the request cycle; pixels return ROM_LAT clocks after each read.
// Backpressure: engines hold req until gnt; one burst at a time, back-to-back bursts with no idle cycle between them.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 24,
  parameter int LEN_W   = 6,
  parameter int ROM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_re,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic                      rd_last
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Burst bookkeeping
  logic [0:0]        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [ADDR_W-1:0] start_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;

  // Per-requester views of the flattened request buses
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [LEN_W-1:0]  len_arr  [NUM_REQ];

  // Arbitration result
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic              grant_fire;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  // Address issued this cycle (grant cycle or burst continuation)
  logic              burst_last;
  logic              iss_vld;
  logic [ADDR_W-1:0] iss_addr;
  logic [IDX_W-1:0]  iss_owner;
  logic              iss_last;
  logic [IDX_W-1:0]  ptr_nxt;

  // Return pipeline, one stage per clock of ROM latency
  logic              pipe_vld  [ROM_LAT];
  logic [IDX_W-1:0]  pipe_own  [ROM_LAT];
  logic              pipe_last [ROM_LAT];
  logic [DATA_W-1:0] hold_q;

  // Slice the flattened request buses into per-requester arrays
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
  end

  // Round-robin pick: first requesting engine at or after ptr_q, wrapping around
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // A grant only happens when no burst is issuing; reset forces every output low at once
  assign grant_fire = Reset && (state_q == ST_IDLE) && pick_vld;
  assign sel_addr   = addr_arr[pick_idx];
  assign sel_len    = (len_arr[pick_idx] == '0) ? LEN_W'(1) : len_arr[pick_idx];
  assign burst_last = (state_q == ST_BURST) && (count_q == len_q - LEN_W'(1));

  // Select which address goes to the ROM this cycle and who owns it
  always_comb begin
    iss_vld   = 1'b0;
    iss_addr  = '0;
    iss_owner = '0;
    iss_last  = 1'b0;
    if (grant_fire) begin
      iss_vld   = 1'b1;
      iss_addr  = sel_addr;
      iss_owner = pick_idx;
      iss_last  = (sel_len == LEN_W'(1));
    end else if (state_q == ST_BURST) begin
      iss_vld   = 1'b1;
      iss_addr  = start_q + ADDR_W'(count_q);
      iss_owner = owner_q;
      iss_last  = burst_last;
    end
  end

  // Round-robin pointer moves just past the owner of the finishing burst
  always_comb begin
    if (iss_owner == IDX_W'(NUM_REQ - 1)) ptr_nxt = '0;
    else                                  ptr_nxt = iss_owner + IDX_W'(1);
  end

  // One-hot grant pulse
  always_comb begin
    gnt = '0;
    if (grant_fire) gnt[pick_idx] = 1'b1;
  end

  assign rom_re   = iss_vld;
  assign rom_addr = iss_addr;
  assign busy     = iss_vld;

  // Burst FSM: latch the granted request, then step through the remaining pixels
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      start_q <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else if (grant_fire) begin
      owner_q <= pick_idx;
      start_q <= sel_addr;
      len_q   <= sel_len;
      count_q <= LEN_W'(1);
      state_q <= (sel_len == LEN_W'(1)) ? ST_IDLE : ST_BURST;
    end else if (state_q == ST_BURST) begin
      if (burst_last) state_q <= ST_IDLE;
      else            count_q <= count_q + LEN_W'(1);
    end
  end

  // Pointer update on the last address of every burst, including single-pixel ones
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                    ptr_q <= '0;
    else if (iss_vld && iss_last)  ptr_q <= ptr_nxt;
  end

  // Return pipeline tracks owner and last flag alongside each outstanding ROM read
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        pipe_vld[k]  <= 1'b0;
        pipe_own[k]  <= '0;
        pipe_last[k] <= 1'b0;
      end
    end else begin
      pipe_vld[0]  <= iss_vld;
      pipe_own[0]  <= iss_owner;
      pipe_last[0] <= iss_vld && iss_last;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_own[k]  <= pipe_own[k-1];
        pipe_last[k] <= pipe_last[k-1];
      end
    end
  end

  // Remember the last delivered pixel so rd_data stays put between valids
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                      hold_q <= '0;
    else if (pipe_vld[ROM_LAT-1])    hold_q <= rom_data;
  end

  // Steer the returning pixel to its owner
  always_comb begin
    rd_valid = '0;
    if (pipe_vld[ROM_LAT-1]) rd_valid[pipe_own[ROM_LAT-1]] = 1'b1;
  end

  assign rd_last = pipe_vld[ROM_LAT-1] && pipe_last[ROM_LAT-1];
  assign rd_data = pipe_vld[ROM_LAT-1] ? rom_data : hold_q;

endmodule
